// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioner.
// Imported by debounce_ch and button_conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FIRED
    } chord_state_t;

    localparam int unsigned DEF_N_CH            = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam bit          DEF_ACTIVE_LOW      = 1'b1;
    localparam int unsigned DEF_CHORD_HOLD      = 4;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, polarity fix, stability counter,
// debounced level and registered press/release pulses.
module debounce_ch
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    TERMINAL = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic             RAW_IDLE = ACTIVE_LOW;

    logic [1:0]    sync;
    logic          sample;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {2{RAW_IDLE}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign sample = sync[1] ^ ACTIVE_LOW;

    // The counter only ever runs while sample disagrees with level, so it
    // clears either on agreement or on acceptance and can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (sample == level) begin
                count <= '0;
            end else if (count == TERMINAL) begin
                count         <= '0;
                level         <= sample;
                press         <= sample;
                release_pulse <= ~sample;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per-channel debounce with edge
// pulses, plus a chord detector that fires once per sustained hold.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned         N_CH            = DEF_N_CH,
    parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit                  ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter logic [N_CH-1:0]     CHORD_MASK      = '1,
    parameter int unsigned         CHORD_HOLD      = DEF_CHORD_HOLD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic            chord
);

    localparam int unsigned   HW        = $clog2(CHORD_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CHORD_HOLD - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .raw          (btn_raw[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

    chord_state_t  state, state_next;
    logic [HW-1:0] hold, hold_next;
    logic          all_held, none_held;

    assign all_held  = (level & CHORD_MASK) == CHORD_MASK;
    assign none_held = (level & CHORD_MASK) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // chord is decoded from the ARM terminal count so it lands exactly
    // CHORD_HOLD cycles after the chord forms and clears with reset at once.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        chord      = 1'b0;
        case (state)
            IDLE: begin
                if (all_held) begin
                    state_next = ARM;
                    hold_next  = '0;
                end
            end
            ARM: begin
                if (!all_held) begin
                    state_next = IDLE;
                end else if (hold == HOLD_LAST) begin
                    state_next = FIRED;
                    chord      = 1'b1;
                end else begin
                    hold_next = hold + 1'b1;
                end
            end
            FIRED: begin
                if (none_held) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed stimulus queues expected
// pulses, a negedge monitor matches every observed pulse against the queue.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] level, press, release_pulse;
    logic       chord;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    ev_t exp_q[$];

    button_conditioner #(
        .N_CH           (2),
        .DEBOUNCE_CYCLES(16),
        .ACTIVE_LOW     (1'b1),
        .CHORD_MASK     (2'b11),
        .CHORD_HOLD     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .chord        (chord)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            0:       return "press";
            1:       return "release";
            default: return "chord";
        endcase
    endfunction

    task automatic push(input int kind, input int ch, input int c);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic match(input int kind, input int ch);
        int  idx;
        logic lvl_ok;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch && exp_q[i].cyc == cyc)
                idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_%s ch%0d at cycle %0d: got 1, expected 0",
                     kind_name(kind), ch, cyc);
        end else begin
            exp_q.delete(idx);
            lvl_ok = (kind == 0) ? (level[ch] === 1'b1) :
                     (kind == 1) ? (level[ch] === 1'b0) : 1'b1;
            if (!lvl_ok) begin
                errors++;
                $display("FAIL level_with_%s ch%0d at cycle %0d: got %0b, expected %0b",
                         kind_name(kind), ch, cyc, level[ch], (kind == 0));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (press[ch] === 1'b1)         match(0, ch);
            if (release_pulse[ch] === 1'b1) match(1, ch);
        end
        if (chord === 1'b1) match(2, 0);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_%s ch%0d: got 0 at cycle %0d, expected 1",
                         kind_name(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        #10000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        at_cycle(2);
        check("reset_outputs", {25'd0, level, press, release_pulse, chord}, 32'd0);
        at_cycle(3);
        rst = 1'b0;

        // Clean press on ch0
        at_cycle(10);
        btn_raw[0] = 1'b0;
        push(0, 0, 28);
        at_cycle(27);
        check("level0_before", {31'd0, level[0]}, 32'd0);
        at_cycle(28);
        check("level0_rise", {31'd0, level[0]}, 32'd1);
        at_cycle(29);
        check("press0_one_cycle", {31'd0, press[0]}, 32'd0);

        // 10-cycle glitch on ch1
        at_cycle(40);
        btn_raw[1] = 1'b0;
        at_cycle(50);
        btn_raw[1] = 1'b1;
        for (int c = 51; c <= 75; c++) begin
            at_cycle(c);
            check("glitch_level1", {31'd0, level[1]}, 32'd0);
        end

        // Full chord, held long, then simultaneous release
        at_cycle(80);
        btn_raw[1] = 1'b0;
        push(0, 1, 98);
        push(2, 0, 102);
        at_cycle(310);
        btn_raw = 2'b11;
        push(1, 0, 328);
        push(1, 1, 328);

        // Both levels high for only 2 cycles: no chord
        at_cycle(340);
        btn_raw[0] = 1'b0;
        push(0, 0, 358);
        at_cycle(370);
        btn_raw[1] = 1'b0;
        at_cycle(372);
        btn_raw[0] = 1'b1;
        push(0, 1, 388);
        push(1, 0, 390);

        // FSM back in IDLE: re-forming the chord fires it
        at_cycle(400);
        btn_raw[0] = 1'b0;
        push(0, 0, 418);
        push(2, 0, 422);

        // Partial release and re-press while FIRED: no second chord
        at_cycle(430);
        btn_raw[0] = 1'b1;
        push(1, 0, 448);
        at_cycle(460);
        btn_raw[0] = 1'b0;
        push(0, 0, 478);

        // Reset while ch1 is mid release-count and ch0 is held
        at_cycle(482);
        btn_raw[1] = 1'b1;
        at_cycle(489);
        check("levels_before_reset", {30'd0, level}, 32'd3);
        at_cycle(490);
        rst = 1'b1;
        #1;
        check("reset_async_clear", {25'd0, level, press, release_pulse, chord}, 32'd0);
        at_cycle(491);
        check("reset_hold_a", {25'd0, level, press, release_pulse, chord}, 32'd0);
        at_cycle(492);
        check("reset_hold_b", {25'd0, level, press, release_pulse, chord}, 32'd0);
        at_cycle(493);
        rst = 1'b0;
        push(0, 0, 511);
        at_cycle(510);
        check("requal_level0_before", {31'd0, level[0]}, 32'd0);

        // Clean release on ch0
        at_cycle(530);
        btn_raw[0] = 1'b1;
        push(1, 0, 548);
        at_cycle(547);
        check("level0_before_fall", {31'd0, level[0]}, 32'd1);
        at_cycle(548);
        check("level0_fall", {31'd0, level[0]}, 32'd0);

        at_cycle(600);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
